// File: rtl/spi_pkg.sv
// Shared types and constants for the oversampled SPI register-bus slave.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HDR  = 2'b01,
    ST_DATA = 2'b10
  } state_t;

  localparam logic CPOL_LOW   = 1'b0;
  localparam logic CPOL_HIGH  = 1'b1;
  localparam logic CPHA_LEAD  = 1'b0;
  localparam logic CPHA_TRAIL = 1'b1;

  // Width needed to hold the values 0..n.
  function automatic int bits_for(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/spi_slave_sync_edge.sv
// Multi-flop synchroniser for one asynchronous SPI pin, plus a delayed copy
// used to produce single-cycle rise/fall pulses in the clk domain.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   level_p1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_p0  <= {SYNC_STAGES{RST_VAL}};
      level_p1 <= RST_VAL;
    end else begin
      sync_p0  <= {sync_p0[SYNC_STAGES-2:0], din};
      level_p1 <= sync_p0[SYNC_STAGES-1];
    end
  end

  assign level = sync_p0[SYNC_STAGES-1];
  assign rise  = level & ~level_p1;
  assign fall  = ~level & level_p1;

endmodule

// File: rtl/spi_slave_sync.sv
// SPI register-bus slave running entirely in the clk domain: header of
// direction + address, then DSZ-bit data words with address auto-increment.
module spi_slave_sync
  import spi_pkg::*;
#(
  parameter int ASZ         = 7,
  parameter int DSZ         = 32,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int SYNC_STAGES = 2,
  parameter int RD_LAT      = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           spiclk,
  input  logic           spimosi,
  output logic           spimiso,
  input  logic           spicsl,
  output logic           we,
  output logic           re,
  output logic           rd,
  output logic [ASZ-1:0] addr,
  output logic [DSZ-1:0] wdat,
  input  logic [DSZ-1:0] rdat,
  output logic           busy,
  output logic           frame_err
);

  localparam int   CW  = bits_for(ASZ + DSZ);
  localparam logic POL = (CPOL != 0) ? CPOL_HIGH : CPOL_LOW;
  localparam logic PHA = (CPHA != 0) ? CPHA_TRAIL : CPHA_LEAD;

  state_t state, state_nxt;

  logic sclk_level, sclk_rise, sclk_fall;
  logic cs_level, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_p0;
  logic mosi_s;
  logic lead, trail, sample_ok, shift_ok, hdr_done;

  logic [CW-1:0]     cnt;
  logic [DSZ-1:0]    rx_sh;
  logic [DSZ-1:0]    tx_sh;
  logic [DSZ-1:0]    pref;
  logic [RD_LAT-1:0] re_pipe;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(POL)) u_sclk (
    .clk   (clk),
    .reset (reset),
    .din   (spiclk),
    .level (sclk_level),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  // Chip select idles high, so the synchroniser resets high: no false frame start.
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .clk   (clk),
    .reset (reset),
    .din   (spicsl),
    .level (cs_level),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  // Same depth as the clock path so MOSI lines up with the detected edge.
  always_ff @(posedge clk) begin
    if (!reset) mosi_p0 <= '0;
    else        mosi_p0 <= {mosi_p0[SYNC_STAGES-2:0], spimosi};
  end
  assign mosi_s = mosi_p0[SYNC_STAGES-1];

  always_comb begin
    lead      = (sclk_rise | sclk_fall) & (sclk_level != POL);
    trail     = (sclk_rise | sclk_fall) & (sclk_level == POL);
    sample_ok = ((PHA == CPHA_LEAD) ? lead : trail) & ~cs_rise;
    shift_ok  = ((PHA == CPHA_LEAD) ? trail : lead) & ~cs_rise;
    hdr_done  = (state == ST_HDR) && sample_ok && (cnt == CW'(ASZ));
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (cs_fall) state_nxt = ST_HDR;
      ST_HDR: begin
        if (cs_rise)       state_nxt = ST_IDLE;
        else if (hdr_done) state_nxt = ST_DATA;
      end
      ST_DATA: if (cs_rise) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy    = ~cs_level;
    spimiso = 1'b0;
    if (state == ST_DATA && rd) spimiso = tx_sh[DSZ-1];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt       <= '0;
      rx_sh     <= '0;
      tx_sh     <= '0;
      pref      <= '0;
      re_pipe   <= '0;
      we        <= 1'b0;
      re        <= 1'b0;
      rd        <= 1'b0;
      addr      <= '0;
      wdat      <= '0;
      frame_err <= 1'b0;
    end else begin
      we        <= 1'b0;
      re        <= 1'b0;
      frame_err <= 1'b0;
      // Prefetch: rdat is valid RD_LAT cycles after the re pulse.
      re_pipe[0] <= re;
      for (int i = 1; i < RD_LAT; i++) re_pipe[i] <= re_pipe[i-1];
      if (re_pipe[RD_LAT-1]) pref <= rdat;
      if (we) addr <= addr + 1'b1;

      case (state)
        ST_IDLE: begin
          if (cs_fall) begin
            cnt   <= '0;
            rd    <= 1'b0;
            tx_sh <= '0;
          end
        end
        ST_HDR: begin
          if (cs_rise) begin
            frame_err <= 1'b1;
          end else if (sample_ok) begin
            rx_sh <= {rx_sh[DSZ-2:0], mosi_s};
            if (cnt == '0) rd <= mosi_s;
            if (hdr_done) begin
              addr <= ASZ'({rx_sh, mosi_s});
              cnt  <= '0;
              re   <= rd;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (cs_rise) begin
            if (cnt != '0) frame_err <= 1'b1;
          end else begin
            if (sample_ok) begin
              rx_sh <= {rx_sh[DSZ-2:0], mosi_s};
              if (cnt == CW'(DSZ - 1)) begin
                cnt <= '0;
                if (!rd) begin
                  wdat <= DSZ'({rx_sh, mosi_s});
                  we   <= 1'b1;
                end
              end else begin
                cnt <= cnt + 1'b1;
              end
              if (rd && cnt == '0) begin
                addr <= addr + 1'b1;
                re   <= 1'b1;
              end
            end
            // Word boundary reloads from the prefetch register, otherwise shift.
            if (shift_ok && rd) begin
              if (cnt == '0) tx_sh <= pref;
              else           tx_sh <= {tx_sh[DSZ-2:0], 1'b0};
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_sync.sv
// Directed bench: one slave per SPI mode (instance index = mode number),
// a SPI master task, and a register model answering read requests.
module tb_spi_slave_sync;

  localparam int HALF = 10;

  typedef struct {
    int         inst;
    logic [6:0] a;
    logic [31:0] d;
  } rec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        mosi;
  logic        spiclk_m [4];
  logic        spicsl_m [4];
  logic        miso_m   [4];
  logic        we_m     [4];
  logic        re_m     [4];
  logic        rd_m     [4];
  logic [6:0]  addr_m   [4];
  logic [31:0] wdat_m   [4];
  logic [31:0] rdat_m   [4];
  logic        busy_m   [4];
  logic        ferr_m   [4];

  rec_t we_q[$];
  rec_t re_q[$];
  int   ferr_cnt [4] = '{default: 0};
  int   miso_hi  [4] = '{default: 0};

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave_sync #(
      .ASZ(7), .DSZ(32), .CPOL(g / 2), .CPHA(g % 2), .SYNC_STAGES(2), .RD_LAT(1)
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .spiclk    (spiclk_m[g]),
      .spimosi   (mosi),
      .spimiso   (miso_m[g]),
      .spicsl    (spicsl_m[g]),
      .we        (we_m[g]),
      .re        (re_m[g]),
      .rd        (rd_m[g]),
      .addr      (addr_m[g]),
      .wdat      (wdat_m[g]),
      .rdat      (rdat_m[g]),
      .busy      (busy_m[g]),
      .frame_err (ferr_m[g])
    );
  end

  function automatic logic [31:0] rmodel(input logic [6:0] a);
    case (a)
      7'h2A:   return 32'hA5A5_0F0F;
      7'h10:   return 32'h1234_5678;
      7'h11:   return 32'hCAFE_F00D;
      default: return {25'h0, a} ^ 32'h5555_0000;
    endcase
  endfunction

  // Register model: data appears one cycle after the read request.
  always @(posedge clk) begin
    for (int g = 0; g < 4; g++)
      if (re_m[g]) rdat_m[g] <= rmodel(addr_m[g]);
  end

  always @(negedge clk) begin
    for (int g = 0; g < 4; g++) begin
      if (we_m[g]) we_q.push_back('{g, addr_m[g], wdat_m[g]});
      if (re_m[g]) re_q.push_back('{g, addr_m[g], 32'h0});
      if (ferr_m[g]) ferr_cnt[g]++;
      if (miso_m[g]) miso_hi[g]++;
    end
  end

  task automatic spi_frame(input int m, input logic [127:0] tx, input int nbits,
                           input bit keep_cs, output logic [127:0] rx);
    logic cpol, cpha;
    cpol = (m >= 2);
    cpha = ((m % 2) == 1);
    rx = '0;
    spicsl_m[m] = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = nbits - 1; i >= 0; i--) begin
      if (!cpha) begin
        mosi = tx[i];
        repeat (HALF) @(negedge clk);
        rx = {rx[126:0], miso_m[m]};
        spiclk_m[m] = ~cpol;
        repeat (HALF) @(negedge clk);
        spiclk_m[m] = cpol;
      end else begin
        spiclk_m[m] = ~cpol;
        mosi = tx[i];
        repeat (HALF) @(negedge clk);
        rx = {rx[126:0], miso_m[m]};
        spiclk_m[m] = cpol;
        repeat (HALF) @(negedge clk);
      end
    end
    if (!keep_cs) begin
      repeat (HALF) @(negedge clk);
      spicsl_m[m] = 1'b1;
      repeat (HALF) @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    mosi  = 1'b0;
    for (int g = 0; g < 4; g++) begin
      spicsl_m[g] = 1'b1;
      spiclk_m[g] = (g >= 2);
    end
    repeat (5) @(negedge clk);
    vectors++; if (we_m[0] !== 1'b0) begin miscompares++; $display("FAIL reset_we: got %b expected 0", we_m[0]); end
    vectors++; if (re_m[0] !== 1'b0) begin miscompares++; $display("FAIL reset_re: got %b expected 0", re_m[0]); end
    vectors++; if (addr_m[0] !== 7'h0) begin miscompares++; $display("FAIL reset_addr: got %h expected 00", addr_m[0]); end
    vectors++; if (wdat_m[0] !== 32'h0) begin miscompares++; $display("FAIL reset_wdat: got %h expected 0", wdat_m[0]); end
    vectors++; if (miso_m[0] !== 1'b0) begin miscompares++; $display("FAIL reset_miso: got %b expected 0", miso_m[0]); end
    vectors++; if (busy_m[0] !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy_m[0]); end
    for (int g = 1; g < 4; g++) begin
      vectors++;
      if ({we_m[g], re_m[g], rd_m[g], addr_m[g], wdat_m[g], miso_m[g], busy_m[g], ferr_m[g]} !== 46'h0) begin
        miscompares++;
        $display("FAIL reset_outputs_mode%0d: got %h expected 0", g,
                 {we_m[g], re_m[g], rd_m[g], addr_m[g], wdat_m[g], miso_m[g], busy_m[g], ferr_m[g]});
      end
    end
    reset = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_write_mode0;
    logic [127:0] rx;
    int w0, f0, m0, r0;
    w0 = we_q.size(); r0 = re_q.size(); f0 = ferr_cnt[0]; m0 = miso_hi[0];
    spi_frame(0, {88'h0, 1'b0, 7'h15, 32'hDEAD_BEEF}, 40, 1'b0, rx);
    vectors++; if (we_q.size() - w0 !== 1) begin miscompares++; $display("FAIL wr0_we_count: got %0d expected 1", we_q.size() - w0); end
    if (we_q.size() > w0) begin
      vectors++; if (we_q[w0].a !== 7'h15) begin miscompares++; $display("FAIL wr0_addr: got %h expected 15", we_q[w0].a); end
      vectors++; if (we_q[w0].d !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL wr0_wdat: got %h expected deadbeef", we_q[w0].d); end
    end
    vectors++; if (miso_hi[0] - m0 !== 0) begin miscompares++; $display("FAIL wr0_miso_idle: got %0d high cycles expected 0", miso_hi[0] - m0); end
    vectors++; if (ferr_cnt[0] - f0 !== 0) begin miscompares++; $display("FAIL wr0_frame_err: got %0d expected 0", ferr_cnt[0] - f0); end
    vectors++; if (re_q.size() - r0 !== 0) begin miscompares++; $display("FAIL wr0_re_count: got %0d expected 0", re_q.size() - r0); end
    vectors++; if (busy_m[0] !== 1'b0) begin miscompares++; $display("FAIL wr0_busy_after: got %b expected 0", busy_m[0]); end
  endtask

  task automatic test_read_mode3;
    logic [127:0] rx;
    int r0, n2a, f0;
    r0 = re_q.size(); f0 = ferr_cnt[3];
    spi_frame(3, {88'h0, 1'b1, 7'h2A, 32'h0}, 40, 1'b0, rx);
    n2a = 0;
    for (int i = r0; i < re_q.size(); i++) if (re_q[i].a == 7'h2A) n2a++;
    vectors++; if (n2a !== 1) begin miscompares++; $display("FAIL rd3_re_count_2a: got %0d expected 1", n2a); end
    if (re_q.size() > r0) begin
      vectors++; if (re_q[r0].a !== 7'h2A) begin miscompares++; $display("FAIL rd3_first_re_addr: got %h expected 2a", re_q[r0].a); end
    end
    vectors++; if (rx[31:0] !== 32'hA5A5_0F0F) begin miscompares++; $display("FAIL rd3_miso_word: got %h expected a5a50f0f", rx[31:0]); end
    vectors++; if (rx[39:32] !== 8'h00) begin miscompares++; $display("FAIL rd3_miso_hdr: got %h expected 00", rx[39:32]); end
    vectors++; if (ferr_cnt[3] - f0 !== 0) begin miscompares++; $display("FAIL rd3_frame_err: got %0d expected 0", ferr_cnt[3] - f0); end
  endtask

  task automatic test_burst_write_mode1;
    logic [127:0] rx;
    logic [6:0]  ea [3];
    logic [31:0] ed [3];
    int w0;
    ea = '{7'h7E, 7'h7F, 7'h00};
    ed = '{32'h1111_2222, 32'h3333_4444, 32'h8000_0001};
    w0 = we_q.size();
    spi_frame(1, {24'h0, 1'b0, 7'h7E, 32'h1111_2222, 32'h3333_4444, 32'h8000_0001}, 104, 1'b0, rx);
    vectors++; if (we_q.size() - w0 !== 3) begin miscompares++; $display("FAIL bw1_we_count: got %0d expected 3", we_q.size() - w0); end
    for (int k = 0; k < 3; k++) begin
      if (we_q.size() > w0 + k) begin
        vectors++;
        if (we_q[w0+k].a !== ea[k] || we_q[w0+k].d !== ed[k] || we_q[w0+k].inst !== 1) begin
          miscompares++;
          $display("FAIL bw1_word%0d: got inst %0d addr %h data %h expected inst 1 addr %h data %h",
                   k, we_q[w0+k].inst, we_q[w0+k].a, we_q[w0+k].d, ea[k], ed[k]);
        end
      end
    end
    vectors++; if (addr_m[1] !== 7'h01) begin miscompares++; $display("FAIL bw1_addr_after: got %h expected 01", addr_m[1]); end
  endtask

  task automatic test_burst_read_mode2;
    logic [127:0] rx;
    int r0;
    r0 = re_q.size();
    spi_frame(2, {56'h0, 1'b1, 7'h10, 64'h0}, 72, 1'b0, rx);
    vectors++; if (rx[63:0] !== 64'h1234_5678_CAFE_F00D) begin miscompares++; $display("FAIL br2_data: got %h expected 12345678cafef00d", rx[63:0]); end
    vectors++; if (re_q.size() - r0 < 2) begin miscompares++; $display("FAIL br2_re_count: got %0d expected at least 2", re_q.size() - r0); end
    else begin
      vectors++; if (re_q[r0].a !== 7'h10) begin miscompares++; $display("FAIL br2_re0_addr: got %h expected 10", re_q[r0].a); end
      vectors++; if (re_q[r0+1].a !== 7'h11) begin miscompares++; $display("FAIL br2_re1_addr: got %h expected 11", re_q[r0+1].a); end
    end
  endtask

  task automatic test_abort;
    logic [127:0] rx;
    int w0, f0;
    w0 = we_q.size(); f0 = ferr_cnt[0];
    spi_frame(0, {100'h0, 1'b0, 7'h33, 20'hABCDE}, 28, 1'b0, rx);
    vectors++; if (we_q.size() - w0 !== 0) begin miscompares++; $display("FAIL abort_we: got %0d expected 0", we_q.size() - w0); end
    vectors++; if (ferr_cnt[0] - f0 !== 1) begin miscompares++; $display("FAIL abort_frame_err: got %0d expected 1", ferr_cnt[0] - f0); end
    vectors++;
    if (g_dut[0].u_dut.state !== spi_pkg::ST_IDLE) begin
      miscompares++;
      $display("FAIL abort_state: got %0d expected %0d", g_dut[0].u_dut.state, spi_pkg::ST_IDLE);
    end
    w0 = we_q.size(); f0 = ferr_cnt[0];
    spi_frame(0, {88'h0, 1'b0, 7'h16, 32'h0123_4567}, 40, 1'b0, rx);
    vectors++; if (we_q.size() - w0 !== 1) begin miscompares++; $display("FAIL abort_next_count: got %0d expected 1", we_q.size() - w0); end
    else begin
      vectors++;
      if (we_q[w0].a !== 7'h16 || we_q[w0].d !== 32'h0123_4567) begin
        miscompares++;
        $display("FAIL abort_next_word: got addr %h data %h expected addr 16 data 01234567", we_q[w0].a, we_q[w0].d);
      end
    end
    vectors++; if (ferr_cnt[0] - f0 !== 0) begin miscompares++; $display("FAIL abort_next_ferr: got %0d expected 0", ferr_cnt[0] - f0); end
  endtask

  task automatic test_reset_mid_data;
    logic [127:0] rx;
    int w0, f0;
    w0 = we_q.size(); f0 = ferr_cnt[0];
    spi_frame(0, {108'h0, 1'b0, 7'h44, 12'hABC}, 20, 1'b1, rx);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({we_m[0], re_m[0], rd_m[0], addr_m[0], wdat_m[0], miso_m[0], busy_m[0], ferr_m[0]} !== 46'h0) begin
      miscompares++;
      $display("FAIL rstmid_outputs: got %h expected 0",
               {we_m[0], re_m[0], rd_m[0], addr_m[0], wdat_m[0], miso_m[0], busy_m[0], ferr_m[0]});
    end
    spicsl_m[0] = 1'b1;
    repeat (8) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    vectors++; if (we_q.size() - w0 !== 0) begin miscompares++; $display("FAIL rstmid_we: got %0d expected 0", we_q.size() - w0); end
    vectors++; if (ferr_cnt[0] - f0 !== 0) begin miscompares++; $display("FAIL rstmid_ferr: got %0d expected 0", ferr_cnt[0] - f0); end
    spi_frame(0, {88'h0, 1'b0, 7'h05, 32'h0BAD_F00D}, 40, 1'b0, rx);
    vectors++; if (we_q.size() - w0 !== 1) begin miscompares++; $display("FAIL rstmid_next_count: got %0d expected 1", we_q.size() - w0); end
    else begin
      vectors++;
      if (we_q[w0].a !== 7'h05 || we_q[w0].d !== 32'h0BAD_F00D) begin
        miscompares++;
        $display("FAIL rstmid_next_word: got addr %h data %h expected addr 05 data 0badf00d", we_q[w0].a, we_q[w0].d);
      end
    end
  endtask

  initial begin
    test_reset;
    test_write_mode0;
    test_read_mode3;
    test_burst_write_mode1;
    test_burst_read_mode2;
    test_abort;
    test_reset_mid_data;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
